vga_fetch_scheduler: RTL

- Sequences VGA read traffic into the shared 256Kx16 SRAM memory-bus adapter.
- On each scanline start it fetches WORDS_PER_LINE 16-bit words from a base address into a local FIFO, which feeds the pixel pipeline.
- Requests are rationed in bursts separated by CPU gaps, so the CPU port (stalled whenever a VGA request is active) still gets bandwidth. Urgent refill overrides the gap rule.

---
 rtl/vga_fetch_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vga_fetch_scheduler.sv
// VGA line fetcher: rations SRAM read requests into bursts with CPU gaps and
// buffers the returned words in a first-word-fall-through line FIFO.
module vga_fetch_scheduler #(
  parameter int WORDS_PER_LINE = 320,
  parameter int FIFO_DEPTH     = 16,
  parameter int BURST          = 4,
  parameter int CPU_GAP        = 4,
  parameter int LOW_WATER      = 4,
  parameter int READ_LATENCY   = 2
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_line_start,
  input  logic [17:0] I_line_base,
  output logic        O_vga_req,
  output logic [17:0] O_vga_adr,
  input  logic [15:0] I_vga_dat,
  input  logic        I_pix_rd,
  output logic [15:0] O_pix_dat,
  output logic        O_pix_valid,
  output logic        O_underrun,
  output logic        O_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(WORDS_PER_LINE + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam int GW = $clog2(CPU_GAP + 1);
  localparam int IW = $clog2(READ_LATENCY + 2);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_GAP} state_t;

  state_t                       state_q, state_d;
  logic [17:0]                  addr_q, adr_q;
  logic [RW-1:0]                rem_q;
  logic [BW-1:0]                burst_q;
  logic [GW-1:0]                gap_q;
  // vld_pipe[0] is the request on the bus now; the top stage is the returning word
  logic [READ_LATENCY:0]        vld_pipe;
  logic [IW-1:0]                inflight;
  logic [15:0]                  occupancy;
  logic                         credit_ok, urgent, issue;

  logic [FIFO_DEPTH-1:0][15:0]  mem;
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic [AW:0]                  fifo_cnt;
  logic [15:0]                  last_q;
  logic                         underrun_q, wr_en, pop_en;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= READ_LATENCY; i++) inflight = inflight + IW'(vld_pipe[i]);
  end

  assign occupancy = 16'(fifo_cnt) + 16'(inflight);
  assign credit_ok = occupancy < 16'(FIFO_DEPTH);
  assign urgent    = occupancy < 16'(LOW_WATER);
  // a line restart discards whatever is returning in the same cycle
  assign wr_en     = vld_pipe[READ_LATENCY] && !I_line_start;
  assign pop_en    = I_pix_rd && (fifo_cnt != '0);

  // state register
  always_ff @(posedge I_clk) begin
    if (I_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (I_line_start) state_d = S_FETCH;
    else begin
      case (state_q)
        S_FETCH: begin
          if (rem_q == '0 || (issue && rem_q == RW'(1))) state_d = S_IDLE;
          else if (issue && burst_q == BW'(BURST - 1))  state_d = S_GAP;
        end
        S_GAP:   if (gap_q <= GW'(1) || urgent) state_d = S_FETCH;
        default: ;
      endcase
    end
  end

  // outputs: request decision for the next cycle
  always_comb begin
    issue = 1'b0;
    if (state_q == S_FETCH && !I_line_start) issue = (rem_q != '0) && credit_ok;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      addr_q   <= '0;
      adr_q    <= '0;
      rem_q    <= '0;
      burst_q  <= '0;
      gap_q    <= '0;
      vld_pipe <= '0;
    end else if (I_line_start) begin
      addr_q   <= I_line_base;
      rem_q    <= RW'(WORDS_PER_LINE);
      burst_q  <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[READ_LATENCY-1:0], issue};
      if (issue) begin
        adr_q   <= addr_q;
        addr_q  <= addr_q + 18'd1;
        rem_q   <= rem_q - RW'(1);
        burst_q <= (burst_q == BW'(BURST - 1)) ? '0 : burst_q + BW'(1);
      end
      if (issue && burst_q == BW'(BURST - 1)) gap_q <= GW'(CPU_GAP);
      else if (state_q == S_GAP && gap_q != '0) gap_q <= gap_q - GW'(1);
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      last_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (I_pix_rd && fifo_cnt == '0) underrun_q <= 1'b1;
      if (I_line_start) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop_en) begin
          rd_ptr <= rd_ptr + AW'(1);
          last_q <= mem[rd_ptr];
        end
        fifo_cnt <= fifo_cnt + (AW+1)'(wr_en) - (AW+1)'(pop_en);
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (wr_en) mem[wr_ptr] <= I_vga_dat;
  end

  assign O_vga_req   = vld_pipe[0];
  assign O_vga_adr   = adr_q;
  assign O_pix_valid = (fifo_cnt != '0);
  // when empty, the last word handed to the pixel pipe stays on the bus
  assign O_pix_dat   = (fifo_cnt != '0) ? mem[rd_ptr] : last_q;
  assign O_underrun  = underrun_q;
  assign O_busy      = (rem_q != '0) || (inflight != '0);

endmodule
